// File: rtl/pla_dispatch.sv
// Purpose : decode host control words and dispatch one job at a time to one of NUM_ACC accelerators, reporting done/error status.
// Latency : 1 cycle from an accepted control word (or a done level) to the registered outputs.
// Backpress: none; inputs are sampled every cycle, and a START held through the job never retriggers.
module pla_dispatch #(
    parameter int              NUM_ACC = 3,
    parameter logic [5:0]      OPCODE  = 6'b111111,
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic [31:0]        instruction,
    input  logic [NUM_ACC-1:0] read_done,
    input  logic [NUM_ACC-1:0] write_done,
    output logic [NUM_ACC-1:0] acc_enable,
    output logic               acc_done,
    output logic               busy,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [TO_W-1:0]    run_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_ABORT = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_BAD   = 2'b01;
    localparam logic [1:0] ERR_PROTO = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    // A zero TIMEOUT disables the watchdog; otherwise it fires in the RUN cycle where cnt reaches TIMEOUT-1.
    localparam logic            TO_EN   = (TIMEOUT != '0);
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

    state_t             state_q, state_d;
    logic [NUM_ACC-1:0] acc_enable_q, acc_enable_d;
    logic               acc_done_q, acc_done_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [TO_W-1:0]    run_cycles_q, run_cycles_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;

    logic               ctl_vld;
    logic [1:0]         cmd;
    logic [NUM_ACC-1:0] id_dec;
    logic               start_ok;
    logic               is_start;
    logic               is_abort;
    logic               is_clear;
    logic               is_bad;
    logic               sel_rd;
    logic               sel_wr;
    logic [TO_W-1:0]    cnt_inc;
    logic               to_hit;

    // One-hot decode of the one-based accelerator id; ids 0 and > NUM_ACC decode to all zeros.
    always_comb begin
        id_dec = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            id_dec[i] = (instruction[7:0] == 8'(i + 1));
        end
    end

    // Control-word classification; a word with a foreign opcode is never a control word.
    always_comb begin
        ctl_vld  = chipselect && (instruction[31:26] == OPCODE);
        cmd      = instruction[25:24];
        start_ok = (cmd == CMD_START) && (instruction[23:8] == 16'h0000) && (|id_dec);
        is_start = ctl_vld && start_ok;
        is_abort = ctl_vld && (cmd == CMD_ABORT);
        is_clear = ctl_vld && (cmd == CMD_CLEAR);
        is_bad   = ctl_vld && (((cmd == CMD_START) && !start_ok) || (cmd == CMD_RSVD));
    end

    // The latched enable doubles as the channel select, so only the active channel's done levels matter.
    always_comb begin
        sel_rd  = |(read_done & acc_enable_q);
        sel_wr  = |(write_done & acc_enable_q);
        cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + TO_W'(1));
        to_hit  = TO_EN && (cnt_q == TO_LAST);
    end

    // Next-state and next-output logic; every register holds unless a transition says otherwise.
    always_comb begin
        state_d      = state_q;
        acc_enable_d = acc_enable_q;
        acc_done_d   = acc_done_q;
        busy_d       = busy_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        run_cycles_d = run_cycles_q;
        cnt_d        = cnt_q;

        if (!chipselect) begin
            state_d      = S_IDLE;
            acc_enable_d = '0;
            acc_done_d   = 1'b0;
            busy_d       = 1'b0;
            error_d      = 1'b0;
            err_code_d   = ERR_NONE;
            run_cycles_d = '0;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_start) begin
                        state_d      = S_RUN;
                        acc_enable_d = id_dec;
                        busy_d       = 1'b1;
                        cnt_d        = '0;
                    end else if (is_bad) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_BAD;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_inc;
                    // ABORT reports cycles already completed; every other exit counts the current cycle too.
                    if (is_abort) begin
                        state_d      = S_IDLE;
                        acc_enable_d = '0;
                        busy_d       = 1'b0;
                        run_cycles_d = cnt_q;
                    end else if (sel_wr && !sel_rd) begin
                        state_d      = S_ERR;
                        acc_enable_d = '0;
                        busy_d       = 1'b0;
                        error_d      = 1'b1;
                        err_code_d   = ERR_PROTO;
                        run_cycles_d = cnt_inc;
                    end else if (sel_wr && sel_rd) begin
                        state_d      = S_DONE;
                        acc_enable_d = '0;
                        busy_d       = 1'b0;
                        acc_done_d   = 1'b1;
                        run_cycles_d = cnt_inc;
                    end else if (to_hit) begin
                        state_d      = S_ERR;
                        acc_enable_d = '0;
                        busy_d       = 1'b0;
                        error_d      = 1'b1;
                        err_code_d   = ERR_TMO;
                        run_cycles_d = cnt_inc;
                    end
                end
                S_DONE: begin
                    if (is_clear) begin
                        state_d    = S_IDLE;
                        acc_done_d = 1'b0;
                    end
                end
                S_ERR: begin
                    if (is_clear) begin
                        state_d    = S_IDLE;
                        error_d    = 1'b0;
                        err_code_d = ERR_NONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            acc_enable_q <= '0;
            acc_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            run_cycles_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            acc_enable_q <= acc_enable_d;
            acc_done_q   <= acc_done_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            run_cycles_q <= run_cycles_d;
            cnt_q        <= cnt_d;
        end
    end

    assign acc_enable = acc_enable_q;
    assign acc_done   = acc_done_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign run_cycles = run_cycles_q;

    a_enable_onehot : assert property (@(posedge clk) $onehot0(acc_enable_q));
    a_status_excl   : assert property (@(posedge clk) $onehot0({acc_done_q, busy_q, error_q}));
    a_code_with_err : assert property (@(posedge clk) (error_q == (err_code_q != ERR_NONE)));

endmodule
